serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller. It adds two WIDTH-bit operands plus a carry-in by sequencing one 1-bit full-adder cell over WIDTH consecutive cycles, LSB first. It uses a start/busy/done handshake. It sits beside the combinational adder library as the area-minimal alternative to a parallel ripple adder, for datapaths that can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only when accepting (see Operation)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout hold the new result
- sum  output  WIDTH  result register, held between completions
- cout  output  1  final carry, held between completions

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, capture a, b and cin into internal shift registers (carry register <= cin).
  - Clear the bit counter to 0 and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, the full-adder cell combines a_sh[0], b_sh[0] and the carry register.
  - The sum bit shifts into the MSB of the accumulation register, which shifts right by one.
  - a_sh and b_sh shift right by one.
  - The carry register takes the cell's carry-out.
  - The counter increments.
  - When the counter reaches WIDTH-1, that cycle processes the final bit and the FSM goes to DONE.
- DONE:
  - sum <= accumulation register (with the final bit included); cout <= carry register.
  - Both update on the edge that enters DONE.
  - done=1 for exactly this cycle. Next state is IDLE, or a new RUN if start=1; start is accepted in DONE as in IDLE.
- start while in RUN is ignored: no capture, no effect on the in-flight result, no extra done.
- sum and cout change only on the edge entering DONE, or on reset. They never expose partial results.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). It is exact for all inputs.
- Reset mid-operation aborts:
  - The state goes to IDLE and the counter, shift registers and carry are cleared.
  - No done pulse is produced for the aborted operation.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE.
- Reset has priority over start in the same cycle.
- start is sampled at edge k in IDLE or DONE.
- busy=1 in cycles k+1 .. k+WIDTH.
- done=1 and busy=0 in cycle k+WIDTH+1, with sum/cout valid in that cycle.
- Latency from start to done is WIDTH+1 cycles.
- Maximum throughput is one result per WIDTH+1 cycles, reached when start is held or re-asserted during done.
- busy and done are never high in the same cycle.
- Counter width is $clog2(WIDTH). It never wraps; the terminal count WIDTH-1 ends RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (adder_pkg):
  - state typedef/localparams for IDLE, RUN and DONE (2-bit encoding: 00, 01, 10).
  - MAX_WIDTH=32 constant for the parameter range check.
- One natural sub-module: full_adder_bit.
  - It is a combinational 1-bit full adder built from two half-adder stages plus an OR on the carries.
  - It is instantiated once and fed a_sh[0], b_sh[0] and the carry register.
- The FSM, counter, shift registers and result registers live in serial_adder_ctrl.

## Test plan
- Basic add (WIDTH=8): after reset, drive a=8'h03, b=8'h05, cin=0 with start for 1 cycle.
  - Required: busy for 8 cycles, then done in cycle 9 with sum=8'h08, cout=0.
  - sum stays 8'h00 until done.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start while busy: start a=8'h10, b=8'h20, then re-assert start with a=8'hAA, b=8'h55 at busy cycle 3.
  - Required: exactly one done, sum=8'h30, cout=0.
- Back-to-back: assert start with new operands (8'h7F + 8'h01) in the done cycle of a previous add.
  - Required: busy=1 on the next cycle; second done 9 cycles later with sum=8'h80, cout=0.
  - The first result holds until then.
- Reset mid-RUN: assert rst for 1 cycle at busy cycle 4.
  - Required: next cycle busy=0, done=0, sum=0, cout=0, and no done ever appears for the aborted add.
  - A following start computes correctly.
- Random: 1000 random a, b, cin at WIDTH=8 and WIDTH=13, compared against a+b+cin. Check latency is WIDTH+1 every time.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and width limits.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder: two half-adder stages with the stage carries ORed.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a_i ^ b_i;
  assign ha0_c = a_i & b_i;
  assign s_o   = ha0_s ^ c_i;
  assign ha1_c = ha0_s & c_i;
  assign c_o   = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin over WIDTH cycles, LSB first.
// Start to done is WIDTH+1 cycles; start is ignored while busy.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import adder_pkg::*;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH out of range 2..32");
    end
  endgenerate

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] a_sh_d;
  logic [WIDTH-1:0] b_sh_d;
  logic [WIDTH-1:0] acc_d;

  full_adder_bit u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // The accumulator fills from the MSB so after WIDTH shifts bit 0 lands at sum[0].
  assign a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
  assign b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
  assign acc_d  = {fa_sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          acc_q   <= acc_d;
          carry_q <= fa_cout;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [32:0] res;
    int          exp_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse, check result and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      chk("busy_in_done8", 64'(busy8), 64'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8 actual sum=%0h cout=%0b required no done", sum8, cout8);
      end else begin
        e = q8.pop_front();
        chk("sum8", 64'(sum8), 64'(e.res[7:0]));
        chk("cout8", 64'(cout8), 64'(e.res[8]));
        chk("latency8", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done13) begin
      chk("busy_in_done13", 64'(busy13), 64'd0);
      if (q13.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done13 actual sum=%0h cout=%0b required no done", sum13, cout13);
      end else begin
        e = q13.pop_front();
        chk("sum13", 64'(sum13), 64'(e.res[12:0]));
        chk("cout13", 64'(cout13), 64'(e.res[13]));
        chk("latency13", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, input bit push);
    exp_t e;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    if (push) begin
      e.res = 33'(exp);
      e.exp_cyc = cyc + 9;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue13(input logic [12:0] a, input logic [12:0] b, input logic c,
                         input logic [13:0] exp);
    exp_t e;
    start13 = 1'b1; a13 = a; b13 = b; cin13 = c;
    e.res = 33'(exp);
    e.exp_cyc = cyc + 14;
    q13.push_back(e);
    @(negedge clk);
    start13 = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done8), 64'd1);
  endtask

  task automatic wait_done13(input string name);
    int n = 0;
    while (!done13 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done13), 64'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] exp, input string name);
    issue8(a, b, c, exp, 1'b1);
    wait_done8(name);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with cycle-by-cycle busy and result-hold checks.
    issue8(8'h03, 8'h05, 1'b0, 9'h008, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("basic_busy", 64'(busy8), 64'd1);
      chk("basic_nodone", 64'(done8), 64'd0);
      chk("basic_sum_hold", 64'(sum8), 64'd0);
      @(negedge clk);
    end
    chk("basic_done", 64'(done8), 64'd1);
    @(negedge clk);
    chk("basic_done_pulse", 64'(done8), 64'd0);

    run8(8'hFF, 8'h01, 1'b0, 9'h100, "carry1_done");
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "carry2_done");
    run8(8'h00, 8'h00, 1'b0, 9'h000, "zero_done");

    // Second start during RUN must be ignored.
    issue8(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("ignore_done");
    repeat (15) @(negedge clk);

    // Back-to-back: new start in the done cycle.
    issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    wait_done8("b2b_first_done");
    issue8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    chk("b2b_busy", 64'(busy8), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_hold", 64'(sum8), 64'h03);
      @(negedge clk);
    end
    wait_done8("b2b_second_done");
    @(negedge clk);

    // Reset in busy cycle 4 aborts the add with no done.
    issue8(8'h11, 8'h22, 1'b0, 9'h033, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum", 64'(sum8), 64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    repeat (15) @(negedge clk);
    run8(8'h40, 8'h0C, 1'b1, 9'h04D, "after_abort_done");

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      issue8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1'b1);
      wait_done8("rand8_done");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      logic [12:0] ra, rb;
      logic        rc;
      ra = 13'($urandom);
      rb = 13'($urandom);
      rc = 1'($urandom);
      issue13(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {13'd0, rc});
      wait_done13("rand13_done");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q13_drained", 64'(q13.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
